// File: rtl/csa_word_serial_adder.sv
// Word-serial wide adder: one 8-bit conditional sum adder is reused across
// WORDS byte slices, with the inter-byte carry held in a register.
// Handshake: valid/ready on both the operand and the result side.

// 8-bit conditional sum adder. Each bit computes its sum and carry for both
// possible carry-ins. Adjacent groups are then merged pairwise (1->2->4->8).
// In each merge the low group's carry selects the high group's precomputed
// half.
module conditional_sum_adder (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       c0,
    output logic [7:0] s,
    output logic       c8
);
    for (genvar l = 0; l < 4; l++) begin : g_lvl
        localparam int NG = 8 >> l;   // groups at this level
        localparam int G  = 1 << l;   // bits per group
        localparam int H  = G / 2;    // bits per half group
        // s0/k0 hold the sum and group carries for carry-in 0; s1/k1 for carry-in 1
        logic [7:0]    s0, s1;
        logic [NG-1:0] k0, k1;

        if (l == 0) begin : g_leaf
            assign s0 = x ^ y;
            assign s1 = ~(x ^ y);
            assign k0 = x & y;
            assign k1 = x | y;
        end else begin : g_merge
            for (genvar j = 0; j < NG; j++) begin : g_grp
                // low half passes straight through
                assign s0[j*G +: H] = g_lvl[l-1].s0[j*G +: H];
                assign s1[j*G +: H] = g_lvl[l-1].s1[j*G +: H];
                // high half picks its variant from the low half's carry
                assign s0[j*G+H +: H] = g_lvl[l-1].k0[2*j] ? g_lvl[l-1].s1[j*G+H +: H]
                                                           : g_lvl[l-1].s0[j*G+H +: H];
                assign s1[j*G+H +: H] = g_lvl[l-1].k1[2*j] ? g_lvl[l-1].s1[j*G+H +: H]
                                                           : g_lvl[l-1].s0[j*G+H +: H];
                assign k0[j] = g_lvl[l-1].k0[2*j] ? g_lvl[l-1].k1[2*j+1] : g_lvl[l-1].k0[2*j+1];
                assign k1[j] = g_lvl[l-1].k1[2*j] ? g_lvl[l-1].k1[2*j+1] : g_lvl[l-1].k0[2*j+1];
            end
        end
    end

    assign s  = c0 ? g_lvl[3].s1    : g_lvl[3].s0;
    assign c8 = c0 ? g_lvl[3].k1[0] : g_lvl[3].k0[0];
endmodule

module csa_word_serial_adder #(
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*WORDS-1:0] a,
    input  logic [8*WORDS-1:0] b,
    input  logic               cin,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*WORDS-1:0] sum,
    output logic               cout,
    output logic               ovf,
    output logic               busy
);
    localparam int W  = 8 * WORDS;
    localparam int KW = $clog2(WORDS);
    localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e          state_q;
    logic [W-1:0]    a_q, b_q, sum_q;
    logic            carry_q;
    logic [KW-1:0]   k_q;
    logic            in_ready_q, out_valid_q, busy_q;

    logic [7:0]      x_d, y_d, s_d;
    logic            c8_d;
    logic [KW+2:0]   base_d;

    // byte slice select for the current index
    assign base_d = {k_q, 3'b000};
    assign x_d    = a_q[base_d +: 8];
    assign y_d    = b_q[base_d +: 8];

    conditional_sum_adder u_csa (
        .x  (x_d),
        .y  (y_d),
        .c0 (carry_q),
        .s  (s_d),
        .c8 (c8_d)
    );

    // sequencing FSM: capture, byte-serial accumulate, hold result until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            k_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        carry_q    <= cin;
                        k_q        <= '0;
                        state_q    <= S_RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_RUN: begin
                    sum_q[base_d +: 8] <= s_d;
                    carry_q            <= c8_d;
                    if (k_q == K_LAST) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign cout      = carry_q;
    // signed overflow: like-signed operands whose sum sign differs
    assign ovf       = (a_q[W-1] == b_q[W-1]) && (sum_q[W-1] != a_q[W-1]);
endmodule

// File: tb/tb_csa_word_serial_adder.sv
// Randomised and directed bench for csa_word_serial_adder against an
// arithmetic reference model (plain wide addition).
module tb_csa_word_serial_adder;
    localparam int WORDS = 4;
    localparam int W     = 8 * WORDS;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready;
    logic [W-1:0] a, b;
    logic         cin;
    logic         out_valid, out_ready;
    logic [W-1:0] sum;
    logic         cout, ovf, busy;

    int n_vec = 0;
    int n_err = 0;

    csa_word_serial_adder #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // reference: wide addition plus sign rule
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc,
                         output logic [W-1:0] ms, output logic mco, output logic mov);
        logic [W:0] t;
        t   = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
        ms  = t[W-1:0];
        mco = t[W];
        mov = (ma[W-1] == mb[W-1]) && (ms[W-1] != ma[W-1]);
    endtask

    // one full transaction; hold = cycles of out_ready low in DONE, with
    // junk operands offered meanwhile
    task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc,
                         input int hold);
        logic [W-1:0] es;
        logic         ec, eo;
        int           lat;
        model(oa, ob, oc, es, ec, eo);
        @(negedge clk);
        chk("in_ready_idle", 64'(in_ready), 64'(1));
        a = oa; b = ob; cin = oc; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        lat = 1;
        chk("busy_run", 64'({busy, in_ready}), 64'(2'b10));
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'(WORDS + 1));
        chk("sum", 64'(sum), 64'(es));
        chk("cout_ovf", 64'({cout, ovf}), 64'({ec, eo}));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a = $urandom; b = $urandom; cin = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("hold_state", 64'({out_valid, in_ready}), 64'(2'b10));
            chk("hold_sum", 64'(sum), 64'(es));
            chk("hold_flags", 64'({cout, ovf}), 64'({ec, eo}));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("release", 64'({out_valid, in_ready, busy}), 64'(3'b010));
        chk("idle_hold_sum", 64'(sum), 64'(es));
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic [W-1:0] qa[3], qb[3], es;
        logic         ec, eo;
        int           idx, got, last_t, cyc;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_ctl", 64'({in_ready, out_valid, busy}), 64'(3'b100));
        chk("reset_out", 64'({sum, cout, ovf}), 64'(0));

        // directed cases
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
        do_op(32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 0);
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1);
        do_op(32'h8000_0000, 32'h8000_0000, 1'b0, 3);

        // reset on the second RUN cycle
        @(negedge clk);
        a = 32'h0000_00FF; b = 32'h0000_0001; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrun_rst_ctl", 64'({in_ready, busy, out_valid}), 64'(3'b100));
        chk("midrun_rst_out", 64'({sum, cout}), 64'(0));
        do_op(32'd3, 32'd4, 1'b0, 0);

        // random mix, including both-negative / both-positive extremes
        for (int i = 0; i < 24; i++) begin
            ra = $urandom; rb = $urandom;
            if (i % 4 == 1) begin ra[W-1] = 1'b0; rb[W-1] = 1'b0; end
            if (i % 4 == 2) begin ra[W-1] = 1'b1; rb[W-1] = 1'b1; end
            do_op(ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
        end

        // back-to-back with out_ready tied high
        qa[0] = 32'd1; qb[0] = 32'd1;
        qa[1] = 32'd2; qb[1] = 32'd2;
        qa[2] = 32'hFFFF_FFFF; qb[2] = 32'hFFFF_FFFF;
        idx = 0; got = 0; last_t = -1; cyc = 0;
        @(negedge clk);
        out_ready = 1'b1;
        while (got < 3 && cyc < 100) begin
            if (out_valid) begin
                model(qa[got], qb[got], 1'b0, es, ec, eo);
                chk("b2b_sum", 64'(sum), 64'(es));
                chk("b2b_cout", 64'(cout), 64'(ec));
                if (last_t >= 0) chk("b2b_spacing", 64'(cyc - last_t), 64'(WORDS + 2));
                last_t = cyc;
                got++;
            end
            if (idx < 3) begin
                a = qa[idx]; b = qb[idx]; cin = 1'b0; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            if (in_valid && in_ready) idx++;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("b2b_count", 64'(got), 64'(3));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
